pipelined_slice_adder: RTL
==========================

# pipelined_slice_adder

Parametrised, pipelined add/subtract unit that splits a WIDTH-bit operation into SLICE-bit ripple slices, one slice per pipeline stage, with the inter-slice carry registered between stages. It is the next generation of the team's cascaded 8-bit-slice adders. It adds subtract mode, signed-overflow detection and a valid/ready stream interface so that it can sit directly in datapaths that need full throughput at wide widths.

## Interface
- WIDTH, 32: operand/result width in bits; must be an integer multiple of SLICE, WIDTH ≥ SLICE.
- SLICE, 8: bits resolved per pipeline stage; STAGES = WIDTH/SLICE.
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: A+B+cin; 1: A−B−cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out (add); NOT borrow-out (sub).
- ovf  output  1  signed two's-complement overflow.

## Operation
- Effective operands: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin. sum = (a + b_eff + c0) mod 2^WIDTH. cout = bit WIDTH of that (WIDTH+1)-bit sum.
- Sub semantics: cin=0 gives A−B; cin=1 gives A−B−1. cout=1 means no borrow.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Stage k (0..STAGES−1) adds slice k of a and b_eff plus the carry registered by stage k−1 (c0 for stage 0). It registers:
  - the slice sum,
  - the slice carry-out,
  - all already-finished lower slices,
  - the still-unprocessed upper operand slices,
  - a[MSB] and b_eff[MSB],
  - a per-stage valid bit.
- Inversion of b and cin happens at stage-0 capture. sub is not carried further.
- The last stage register is the output register: sum, cout and ovf are driven directly from it.
- Flow control is a global stall. advance = !out_valid || out_ready. in_ready = advance (combinational). All stage registers, valid bits included, load only when advance=1.
- A beat is accepted when in_valid && in_ready. When advance=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Bubbles do not collapse during a stall; they are held in place.
- While out_valid && !out_ready, sum/cout/ovf and every stage are held stable.
- Data registers of invalid stages are don't-care, except the output register (see reset).
- STAGES=1 degenerates to a single registered full-width adder.

## Timing
- Reset (async assert, sync-safe deassert is the integrator's responsibility):
  - all valid bits = 0, out_valid = 0;
  - sum = 0, cout = 0, ovf = 0;
  - all other stage data = 0.
- After reset, in_ready = 1 immediately.
- Latency: a beat accepted on edge N appears with out_valid=1 after edge N+STAGES−1. It is visible in the cycle following that edge: STAGES cycles from acceptance to first output visibility.
- Throughput: one beat per cycle while out_ready=1. Order is strictly preserved.
- Stall: when out_valid=1 and out_ready=0, in_ready drops in the same cycle. No beat is lost or duplicated.
- Simultaneous out_valid && out_ready && in_valid: the output retires, every stage shifts, and the new beat is captured on the same edge.
- Reset mid-operation: every in-flight beat is discarded. No partial result is ever presented.
- Wrap-around: results are modulo 2^WIDTH, and the carry/borrow is reported only on cout.
- Carry path per stage: one SLICE-bit ripple. There is no combinational path from a/b to sum.

## Test plan
- WIDTH=16, SLICE=8:
  - Basic add and latency: add 00FF+0001 cin=0 → sum=0100, cout=0, ovf=0, out_valid exactly 2 cycles after acceptance.
  - Add with carry-in: add 00FF+0111 cin=1 → 0211, cout=0.
  - Maximum add: FFFF+FFFF cin=1 → FFFF, cout=1, ovf=0.
- WIDTH=16, signed overflow and subtract:
  - add 7FFF+0001 → 8000, cout=0, ovf=1.
  - sub 0000−0001 cin=0 → FFFF, cout=0 (borrow), ovf=0.
  - sub 8000−0001 → 7FFF, cout=1, ovf=1.
  - sub 0005−0003 cin=1 → 0001, cout=1.
- Back-to-back streaming (WIDTH=32, SLICE=8): 100 random beats with in_valid=1 and out_ready=1 → one result per cycle after 4-cycle fill. Every result matches the reference model, in order.
- Backpressure: hold out_ready=0 for 5 cycles with the pipeline full → in_ready=0, outputs stable. Release → beats drain in order with no loss or duplicates. Repeat with random out_ready and in_valid at 50% density.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight (WIDTH=32) → out_valid, sum, cout and ovf go to 0 immediately (asynchronously). After release, no stale beat emerges and a new beat 0000_0001+0000_0001 yields 0000_0002.
- Parameter sweep: WIDTH/SLICE ∈ {8/8, 16/4, 24/8, 64/16}, random add/sub with cin → all match the model, and latency equals WIDTH/SLICE.

Source files
------------

// File: rtl/pipelined_slice_adder.sv
// -----------------------------------------------------------------------------
// pipelined_slice_adder
//
// Pipelined add/subtract unit. A WIDTH-bit operation is split into SLICE-bit
// ripple slices; stage k resolves slice k and registers its carry for stage
// k+1. The last stage register is the output register.
//
// Parameters
//   WIDTH  operand/result width, an integer multiple of SLICE (WIDTH >= SLICE)
//   SLICE  bits resolved per pipeline stage; STAGES = WIDTH/SLICE
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat present
//   in_ready   unit can accept a beat this cycle
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry-out (add) / not-borrow (sub)
//   ovf        signed two's-complement overflow
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. Valid never depends on ready. Flow control is a
// global stall: every stage (valid bits included) loads only when
// advance = !out_valid || out_ready, and in_ready is that same signal, so a
// held result freezes the whole pipe, bubbles included.
// -----------------------------------------------------------------------------
module pipelined_slice_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int LAST   = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is a + ~b + ~cin; the mode is folded into the operands at
  // stage-0 capture and not carried further down the pipe.
  always_comb begin
    b_eff = sub ? ~b : b;
    c0    = sub ? ~cin : cin;
  end

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    // Stage k still needs operand-B bits from slice k upward.
    localparam int BW = WIDTH - SLICE * k;

    logic             src_v;
    logic             src_c;
    logic             src_amsb;
    logic             src_bmsb;
    logic [WIDTH-1:0] src_acc;
    logic [BW-1:0]    src_b;
    logic [SLICE:0]   slice_sum;

    logic             valid_d, valid_q;
    logic             carry_d, carry_q;
    logic             amsb_d, amsb_q;
    logic             bmsb_d, bmsb_q;
    // acc holds finished result slices below and untouched operand-A slices
    // above the current slice; each stage overwrites its own slice.
    logic [WIDTH-1:0] acc_d, acc_q;

    if (k == 0) begin : g_src
      always_comb begin
        src_v    = in_valid;
        src_c    = c0;
        src_amsb = a[WIDTH-1];
        src_bmsb = b_eff[WIDTH-1];
        src_acc  = a;
        src_b    = b_eff;
      end
    end else begin : g_src
      always_comb begin
        src_v    = g_stage[k-1].valid_q;
        src_c    = g_stage[k-1].carry_q;
        src_amsb = g_stage[k-1].amsb_q;
        src_bmsb = g_stage[k-1].bmsb_q;
        src_acc  = g_stage[k-1].acc_q;
        src_b    = g_stage[k-1].g_brem.brem_q;
      end
    end

    always_comb begin
      slice_sum = {1'b0, src_acc[k*SLICE +: SLICE]}
                + {1'b0, src_b[SLICE-1:0]}
                + {{SLICE{1'b0}}, src_c};
      acc_d                    = src_acc;
      acc_d[k*SLICE +: SLICE]  = slice_sum[SLICE-1:0];
      carry_d                  = slice_sum[SLICE];
      valid_d                  = src_v;
      amsb_d                   = src_amsb;
      bmsb_d                   = src_bmsb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        amsb_q  <= 1'b0;
        bmsb_q  <= 1'b0;
        acc_q   <= '0;
      end else if (advance) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        amsb_q  <= amsb_d;
        bmsb_q  <= bmsb_d;
        acc_q   <= acc_d;
      end
    end

    // Unprocessed upper slices of B, passed on to the following stages.
    if (k < LAST) begin : g_brem
      logic [BW-SLICE-1:0] brem_d, brem_q;

      always_comb begin
        brem_d = src_b[BW-1:SLICE];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          brem_q <= '0;
        end else if (advance) begin
          brem_q <= brem_d;
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].valid_q;
  assign sum       = g_stage[LAST].acc_q;
  assign cout      = g_stage[LAST].carry_q;
  // Overflow: operands agree in sign but the result does not. Reset values
  // (all zero) keep this at 0.
  assign ovf       = (g_stage[LAST].amsb_q == g_stage[LAST].bmsb_q) &&
                     (g_stage[LAST].acc_q[WIDTH-1] != g_stage[LAST].amsb_q);

endmodule
